// File: rtl/bitserial_mac_ctrl_if.sv
// Job and engine-facing signal bundle for the bit-serial MAC sequencer.
// The slave side is the sequencer; the master side is the job source plus the adder engine.
interface bitserial_mac_ctrl_if #(
  parameter int ACT_W = 8,
  parameter int WGT_W = 5,
  parameter int SUM_W = 16
);
  logic                       start;
  logic                       clear;
  logic [3:0][ACT_W-1:0]      act;
  logic [3:0][WGT_W-1:0]      wgt;
  logic                       ready;
  logic [SUM_W-1:0]           result;
  logic                       result_valid;
  logic                       adder_init;
  logic [3:0][SUM_W-1:0]      adder_data_in;
  logic [2:0]                 adder_shift_amount;
  logic [SUM_W-1:0]           adder_sum_out;

  modport slave (
    input  start, clear, act, wgt, adder_sum_out,
    output ready, result, result_valid, adder_init, adder_data_in, adder_shift_amount
  );

  modport master (
    output start, clear, act, wgt, adder_sum_out,
    input  ready, result, result_valid, adder_init, adder_data_in, adder_shift_amount
  );
endinterface

// File: rtl/bitserial_mac_ctrl.sv
// Sequencer for a 4-lane bit-serial adder engine: issues one weight bit-plane per cycle
// and captures the signed dot product of four activations and four signed weights.
module bitserial_mac_ctrl #(
  parameter int ACT_W = 8,
  parameter int WGT_W = 5,
  parameter int SUM_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  bitserial_mac_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  localparam logic [2:0] LAST_PLANE = 3'(WGT_W - 1);

  state_t                state, next_state;
  logic [2:0]            plane;
  logic [3:0][ACT_W-1:0] act_q;
  logic [3:0][WGT_W-1:0] wgt_q;
  logic [SUM_W-1:0]      result_q;
  logic                  result_valid_q;
  logic                  accept;

  assign accept           = bus.start && (state == S_IDLE);
  assign bus.ready        = (state == S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

  // NOTE: all state below updates with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      plane          <= '0;
      act_q          <= '0;
      wgt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= next_state;
      result_valid_q <= (state == S_CAPTURE);
      if (state == S_CAPTURE) result_q <= bus.adder_sum_out;
      if (accept) begin
        act_q <= bus.act;
        wgt_q <= bus.wgt;
      end
      plane <= (state == S_ISSUE) ? plane + 3'd1 : 3'd0;
    end
  end

  // The clear decision is taken on the accept edge itself, so it needs no later copy.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (accept) next_state = bus.clear ? S_CLEAR : S_ISSUE;
      S_CLEAR:   next_state = S_ISSUE;
      S_ISSUE:   if (plane == LAST_PLANE) next_state = S_DRAIN;
      S_DRAIN:   next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    bus.adder_init         = 1'b0;
    bus.adder_data_in      = '0;
    bus.adder_shift_amount = '0;
    unique case (state)
      S_CLEAR: bus.adder_init = 1'b1;
      S_ISSUE: begin
        for (int i = 0; i < 4; i++)
          bus.adder_data_in[i] = wgt_q[i][plane] ? SUM_W'(act_q[i]) : '0;
        // The engine applies the shift one cycle after registering the data.
        bus.adder_shift_amount = (plane == 3'd0) ? 3'd0 : plane - 3'd1;
      end
      S_DRAIN: bus.adder_shift_amount = LAST_PLANE;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bitserial_mac_ctrl.sv
// Self-checking bench: behavioural adder engine, directed jobs, and a scoreboard
// monitor that checks result value and accept-to-valid latency.
module tb_bitserial_mac_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitserial_mac_ctrl_if bus ();

  bitserial_mac_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: data_in registered, shift applied to the registered data,
  // subtract at shift 4, init zeroes the sum.
  logic [3:0][15:0] eng_q;
  logic [15:0]      eng_sum;
  assign bus.adder_sum_out = eng_sum;

  function automatic logic [15:0] lane_total(input logic [3:0][15:0] d);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) t = t + d[i];
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_q   <= '0;
      eng_sum <= '0;
    end else begin
      eng_q <= bus.adder_data_in;
      if (bus.adder_init)
        eng_sum <= '0;
      else if (bus.adder_shift_amount == 3'd4)
        eng_sum <= eng_sum - (lane_total(eng_q) << 4);
      else
        eng_sum <= eng_sum + (lane_total(eng_q) << bus.adder_shift_amount);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] val;
    int          acc;
    int          lat;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", {16'd0, bus.result}, {16'd0, mon_e.val});
          check("latency", cyc - mon_e.acc, mon_e.lat);
        end
      end else if (sb.size() > 0 && cyc > sb[0].acc + sb[0].lat) begin
        check("valid_timeout", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic start_job(input logic [3:0][7:0] a, input logic [3:0][4:0] w,
                           input logic clr, input logic [15:0] exp, input bit push);
    bit got_ready;
    sb_t e;
    got_ready = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.ready) begin
        got_ready = 1;
        break;
      end
    end
    if (!got_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.start = 1'b1;
    bus.clear = clr;
    bus.act   = a;
    bus.wgt   = w;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.act   = {$urandom, $urandom};
    bus.wgt   = 20'($urandom);
    bus.clear = 1'($urandom);
    if (push) begin
      e.val = exp;
      e.acc = cyc;
      e.lat = clr ? 8 : 7;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  logic [2:0] exp_shift [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.act   = '0;
    bus.wgt   = '0;
    #23 rst_n = 1'b1;

    @(negedge clk);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_init", {31'd0, bus.adder_init}, 32'd0);
    check("rst_data", bus.adder_data_in[0] | bus.adder_data_in[1] | bus.adder_data_in[2] | bus.adder_data_in[3], 32'd0);
    check("rst_shift", {29'd0, bus.adder_shift_amount}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_sum", {16'd0, bus.adder_sum_out}, 32'd0);
      check("idle_valid", {31'd0, bus.result_valid}, 32'd0);
    end

    // Basic job with shift / init sequence check over CLEAR..CAPTURE.
    start_job({8'd1, 8'd1, 8'd1, 8'd1}, {5'd1, 5'd1, 5'd1, 5'd1}, 1'b1, 16'h0004, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("shift_%0d", i), {29'd0, bus.adder_shift_amount}, {29'd0, exp_shift[i]});
      check($sformatf("init_%0d", i), {31'd0, bus.adder_init}, (i == 0) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Sign plane only: -10.
    start_job({8'd0, 8'd0, 8'd0, 8'd10}, {5'd0, 5'd0, 5'd0, 5'b11111}, 1'b1, 16'hFFF6, 1);
    wait_drain();

    // Extremes.
    start_job({4{8'd255}}, {4{5'b10000}}, 1'b1, 16'hC040, 1);
    start_job({4{8'd255}}, {4{5'd15}}, 1'b1, 16'h3BC4, 1);
    wait_drain();

    // Accumulate: B starts in A's result_valid cycle.
    start_job({8'd0, 8'd0, 8'd0, 8'd3}, {5'd0, 5'd0, 5'd0, 5'd2}, 1'b1, 16'h0006, 1);
    start_job({8'd0, 8'd0, 8'd5, 8'd0}, {5'd0, 5'd0, 5'b11111, 5'd0}, 1'b0, 16'h0001, 1);
    wait_drain();

    // Busy start in ISSUE(2) is ignored: 7*3 = 21.
    start_job({8'd0, 8'd0, 8'd0, 8'd7}, {5'd0, 5'd0, 5'd0, 5'd3}, 1'b1, 16'h0015, 1);
    repeat (4) @(negedge clk);
    check("busy_ready", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b1;
    bus.clear = 1'b1;
    bus.act   = {4{8'd200}};
    bus.wgt   = {4{5'd9}};
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    // Reset during ISSUE(3): aborted, no result.
    start_job({4{8'd50}}, {4{5'd7}}, 1'b1, 16'h0000, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_init", {31'd0, bus.adder_init}, 32'd0);
    check("abort_data", bus.adder_data_in[0] | bus.adder_data_in[1] | bus.adder_data_in[2] | bus.adder_data_in[3], 32'd0);
    check("abort_shift", {29'd0, bus.adder_shift_amount}, 32'd0);
    check("abort_sum", {16'd0, bus.adder_sum_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Fresh job after release, accumulating onto the reset sum: 1+4+9+16 = 30.
    start_job({8'd4, 8'd3, 8'd2, 8'd1}, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b0, 16'h001E, 1);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
